boom_trace_reader: RTL and testbench



---
 rtl/boom_trace_reader.sv | 190 +++++++++++++++++++
 tb/tb_boom_trace_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boom_trace_reader.sv
`default_nettype none
// ============================================================================
// Module   : boom_trace_reader
// Brief    : Walks the BOOM trace ring buffer oldest-to-newest. Each record is
//            read as two 128-bit beats and emitted on a valid/ready stream.
//            Optional exception/interrupt filter: BOOM_TRACE_READER_EXCFILTER_EN
// Revision : 1.0
// ============================================================================
module boom_trace_reader #(
   parameter logic [31:0] BOOM_TRACE_BASEADDR = 32'h0010_0000,
   parameter int unsigned BOOM_TRACE_SIZE     = 'h8000,
   parameter int unsigned BOOM_MEM_DATA_SIZE  = 128,
   parameter int unsigned BOOM_MEM_ADDR_SIZE  = 32,
   localparam int unsigned DEPTH = BOOM_TRACE_SIZE / 32,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          start_i,
   input  logic                          abort_i,
`ifdef BOOM_TRACE_READER_EXCFILTER_EN
   input  logic                          filter_i,
`endif
   output logic                          busy_o,
   output logic                          done_o,
   input  logic [BOOM_MEM_ADDR_SIZE-1:0] trace_ptr_i,
   input  logic [BOOM_MEM_ADDR_SIZE-1:0] trace_count_i,
   output logic                          trace_mem_en_o,
   output logic [BOOM_MEM_ADDR_SIZE-1:0] trace_mem_addr_o,
   input  logic [BOOM_MEM_DATA_SIZE-1:0] trace_mem_rdata_i,
   output logic                          rec_valid_o,
   input  logic                          rec_ready_i,
   output logic [172:0]                  rec_data_o,
   output logic [AW:0]                   rec_idx_o
);

   localparam int unsigned REC_W = 173;
   localparam int unsigned HI_W  = REC_W - BOOM_MEM_DATA_SIZE;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [BOOM_MEM_ADDR_SIZE-1:0] BASE = BOOM_MEM_ADDR_SIZE'(BOOM_TRACE_BASEADDR);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_LO  = 3'd1,
      RD_HI  = 3'd2,
      CAP_HI = 3'd3,
      PUSH   = 3'd4
   } state_t;

   state_t                        state_q;
   logic [AW-1:0]                 idx_q;
   logic [AW:0]                   cnt_q;
   logic [AW:0]                   total_q;
   logic [BOOM_MEM_ADDR_SIZE-1:0] addr_q;
   logic                          en_q;
   logic                          valid_q;
   logic                          done_q;
   logic [REC_W-1:0]              rec_q;

   logic [AW:0]                   w_count_in;
   logic [AW:0]                   w_count_sat;
   logic [AW-1:0]                 w_oldest;
   logic [AW-1:0]                 w_next_idx;
   logic                          w_last;
   logic                          w_skip;
   logic                          w_step;
   logic                          w_unused;

   function automatic logic [BOOM_MEM_ADDR_SIZE-1:0] rec_addr(input logic [AW-1:0] idx,
                                                              input logic          hi);
      logic [BOOM_MEM_ADDR_SIZE-1:0] off;
      off         = '0;
      off[AW+4:0] = {idx, hi, 4'b0000};
      return BASE + off;
   endfunction

   assign w_count_in  = trace_count_i[AW:0];
   assign w_count_sat = (w_count_in > DEPTH_C) ? DEPTH_C : w_count_in;
   // When the buffer is full the subtraction wraps back to the pointer itself.
   assign w_oldest    = trace_ptr_i[AW-1:0] - w_count_sat[AW-1:0];
   assign w_next_idx  = idx_q + 1'b1;
   assign w_last      = ((cnt_q + (AW+1)'(1)) == total_q);

`ifdef BOOM_TRACE_READER_EXCFILTER_EN
   logic filter_q;
   assign w_skip = filter_q && !rec_q[67] && !rec_q[68];
`else
   assign w_skip = 1'b0;
`endif

   assign w_step = ((state_q == CAP_HI) && w_skip) ||
                   ((state_q == PUSH) && rec_ready_i);

   assign w_unused = ^{trace_ptr_i[BOOM_MEM_ADDR_SIZE-1:AW],
                       trace_count_i[BOOM_MEM_ADDR_SIZE-1:AW+1]};

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         total_q <= '0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         rec_q   <= '0;
`ifdef BOOM_TRACE_READER_EXCFILTER_EN
         filter_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (abort_i && (state_q != IDLE)) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0 | 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_i && !abort_i) begin
                     if (w_count_sat == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        total_q <= w_count_sat;
                        cnt_q   <= '0;
                        idx_q   <= w_oldest;
                        addr_q  <= rec_addr(w_oldest, 1'b0);
                        en_q    <= 1'b1;
                        state_q <= RD_LO;
`ifdef BOOM_TRACE_READER_EXCFILTER_EN
                        filter_q <= filter_i;
`endif
                     end
                  end
               end
               RD_LO: begin
                  addr_q  <= rec_addr(idx_q, 1'b1);
                  state_q <= RD_HI;
               end
               RD_HI: begin
                  rec_q[BOOM_MEM_DATA_SIZE-1:0] <= trace_mem_rdata_i;
                  en_q    <= 1'b0;
                  state_q <= CAP_HI;
               end
               CAP_HI: begin
                  rec_q[REC_W-1:BOOM_MEM_DATA_SIZE] <= trace_mem_rdata_i[HI_W-1:0];
                  if (!w_skip) begin
                     valid_q <= 1'b1;
                     state_q <= PUSH;
                  end
               end
               PUSH: begin
                  // Handshake is handled with the filter skip below.
               end
               default: begin
                  state_q <= IDLE;
                  en_q    <= 1'b0;
                  valid_q <= 1'b0;
               end
            endcase

            // Record finished (pushed or filtered out): finish or move on.
            if (w_step) begin
               valid_q <= 1'b0;
               if (w_last) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + (AW+1)'(1);
                  idx_q   <= w_next_idx;
                  addr_q  <= rec_addr(w_next_idx, 1'b0);
                  en_q    <= 1'b1;
                  state_q <= RD_LO;
               end
            end
         end
      end
   end

   assign busy_o           = (state_q != IDLE);
   assign done_o           = done_q;
   assign trace_mem_en_o   = en_q;
   assign trace_mem_addr_o = addr_q;
   assign rec_valid_o      = valid_q && !abort_i;
   assign rec_data_o       = rec_q;
   assign rec_idx_o        = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_boom_trace_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_boom_trace_reader
// Brief    : Self-checking bench for boom_trace_reader against a ring-buffer model.
// Revision : 1.0
// ============================================================================
module tb_boom_trace_reader;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0010_0000;

   logic         clk_i = 1'b0;
   logic         reset_n_i = 1'b0;
   logic         start_i = 1'b0;
   logic         abort_i = 1'b0;
   logic         rec_ready_i = 1'b0;
   logic [31:0]  trace_ptr_i = '0;
   logic [31:0]  trace_count_i = '0;
   logic [127:0] trace_mem_rdata_i;
   logic         busy_o, done_o, trace_mem_en_o, rec_valid_o;
   logic [31:0]  trace_mem_addr_o;
   logic [172:0] rec_data_o;
   logic [10:0]  rec_idx_o;
`ifdef BOOM_TRACE_READER_EXCFILTER_EN
   logic         filter_i = 1'b0;
`endif

   boom_trace_reader dut (
      .clk_i             (clk_i),
      .reset_n_i         (reset_n_i),
      .start_i           (start_i),
      .abort_i           (abort_i),
`ifdef BOOM_TRACE_READER_EXCFILTER_EN
      .filter_i          (filter_i),
`endif
      .busy_o            (busy_o),
      .done_o            (done_o),
      .trace_ptr_i       (trace_ptr_i),
      .trace_count_i     (trace_count_i),
      .trace_mem_en_o    (trace_mem_en_o),
      .trace_mem_addr_o  (trace_mem_addr_o),
      .trace_mem_rdata_i (trace_mem_rdata_i),
      .rec_valid_o       (rec_valid_o),
      .rec_ready_i       (rec_ready_i),
      .rec_data_o        (rec_data_o),
      .rec_idx_o         (rec_idx_o)
   );

   always #5 clk_i = ~clk_i;

   // Trace memory: one record per 32 bytes, data one cycle after the enable.
   logic [172:0] mem [DEPTH];
   logic [31:0]  mem_off;
   always @(posedge clk_i) begin
      if (trace_mem_en_o) begin
         mem_off = trace_mem_addr_o - BASE;
         if (mem_off[4])
            trace_mem_rdata_i <= {83'($urandom()) | 83'h0, mem[mem_off[14:5]][172:128]};
         else
            trace_mem_rdata_i <= mem[mem_off[14:5]][127:0];
      end else begin
         trace_mem_rdata_i <= {$urandom(), $urandom(), $urandom(), $urandom()};
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0]  e_addr_q[$];
   int           e_mem_q[$];
   int           e_pos_q[$];
   int           e_cycles;

   logic [31:0]  ob_addr_q[$];
   int           ob_pos_q[$];
   logic [172:0] ob_data_q[$];
   int           done_cnt, done_cyc, busy_seen, first_valid;

   task automatic fill_mem();
      for (int i = 0; i < DEPTH; i++)
         mem[i] = 173'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
   endtask

   // Reference: oldest = ptr - C (mod DEPTH), C records in order, two beats each.
   task automatic build_expect(input logic [31:0] ptr, input logic [31:0] count, input logic filt);
      int c, o, m;
      c = int'(count[10:0]);
      if (c > DEPTH) c = DEPTH;
      o = (int'(ptr[9:0]) + DEPTH - c) % DEPTH;
      e_addr_q.delete(); e_mem_q.delete(); e_pos_q.delete();
      e_cycles = 1;
      for (int k = 0; k < c; k++) begin
         m = (o + k) % DEPTH;
         e_addr_q.push_back(BASE + 32'(m * 32));
         e_addr_q.push_back(BASE + 32'(m * 32 + 16));
         if (!filt || mem[m][67] || mem[m][68]) begin
            e_mem_q.push_back(m);
            e_pos_q.push_back(k);
            e_cycles += 4;
         end else begin
            e_cycles += 3;
         end
      end
   endtask

   task automatic do_dump(input logic [31:0] ptr, input logic [31:0] count, input logic filt,
                          input int ready_pct, input logic restart);
      ob_addr_q.delete(); ob_pos_q.delete(); ob_data_q.delete();
      done_cnt = 0; done_cyc = -1; busy_seen = 0; first_valid = -1;
      @(negedge clk_i);
      trace_ptr_i = ptr; trace_count_i = count; start_i = 1'b1;
`ifdef BOOM_TRACE_READER_EXCFILTER_EN
      filter_i = filt;
`endif
      @(negedge clk_i);
      start_i = 1'b0; trace_ptr_i = $urandom(); trace_count_i = $urandom();
`ifdef BOOM_TRACE_READER_EXCFILTER_EN
      filter_i = 1'($urandom());
`endif
      for (int cyc = 1; cyc <= 6000; cyc++) begin
         rec_ready_i = ($urandom_range(0, 99) < ready_pct);
         start_i     = restart && (cyc == 6);
         if (busy_o) busy_seen = 1;
         if (trace_mem_en_o) ob_addr_q.push_back(trace_mem_addr_o);
         if (rec_valid_o && first_valid < 0) first_valid = cyc;
         if (rec_valid_o && rec_ready_i) begin
            ob_pos_q.push_back(int'(rec_idx_o));
            ob_data_q.push_back(rec_data_o);
         end
         if (done_o) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
         @(negedge clk_i);
      end
      start_i = 1'b0; rec_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      n_checks++; if ({busy_o, done_o, trace_mem_en_o, rec_valid_o} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl got %b expected 0000", {busy_o, done_o, trace_mem_en_o, rec_valid_o}); end
      n_checks++; if (trace_mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h expected 0", trace_mem_addr_o); end
      n_checks++; if (rec_idx_o !== 11'h0) begin n_fail++; $display("FAIL reset_idx got %0d expected 0", rec_idx_o); end
      n_checks++; if (rec_data_o !== 173'h0) begin n_fail++; $display("FAIL reset_data got %h expected 0", rec_data_o); end
      reset_n_i = 1'b1;
      repeat (2) @(negedge clk_i);
      n_checks++; if ({busy_o, done_o, trace_mem_en_o, rec_valid_o} !== 4'b0) begin n_fail++; $display("FAIL reset_idle got %b expected 0000", {busy_o, done_o, trace_mem_en_o, rec_valid_o}); end
   endtask

   task automatic test_basic();
      fill_mem();
      build_expect(32'd5, 32'd3, 1'b0);
      do_dump(32'd5, 32'd3, 1'b0, 100, 1'b0);
      n_checks++; if (ob_addr_q.size() !== 6) begin n_fail++; $display("FAIL basic_nreads got %0d expected 6", ob_addr_q.size()); end
      for (int i = 0; i < ob_addr_q.size() && i < 6; i++) begin
         n_checks++; if (ob_addr_q[i] !== BASE + 32'h40 + 32'(i * 16)) begin n_fail++; $display("FAIL basic_addr[%0d] got %h expected %h", i, ob_addr_q[i], BASE + 32'h40 + 32'(i * 16)); end
      end
      n_checks++; if (ob_pos_q.size() !== 3) begin n_fail++; $display("FAIL basic_nrecs got %0d expected 3", ob_pos_q.size()); end
      for (int i = 0; i < ob_pos_q.size() && i < 3; i++) begin
         n_checks++; if (ob_pos_q[i] !== i) begin n_fail++; $display("FAIL basic_idx[%0d] got %0d expected %0d", i, ob_pos_q[i], i); end
         n_checks++; if (ob_data_q[i] !== mem[2 + i]) begin n_fail++; $display("FAIL basic_data[%0d] got %h expected %h", i, ob_data_q[i], mem[2 + i]); end
      end
      n_checks++; if (first_valid !== 4) begin n_fail++; $display("FAIL basic_latency got %0d expected 4", first_valid); end
      n_checks++; if (done_cyc !== 13) begin n_fail++; $display("FAIL basic_done_cycle got %0d expected 13", done_cyc); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d expected 1", done_cnt); end
   endtask

   task automatic test_wrap();
      fill_mem();
      build_expect(32'd1, 32'd4, 1'b0);
      do_dump(32'd1, 32'd4, 1'b0, 100, 1'b0);
      n_checks++; if (ob_addr_q.size() !== e_addr_q.size()) begin n_fail++; $display("FAIL wrap_nreads got %0d expected %0d", ob_addr_q.size(), e_addr_q.size()); end
      for (int i = 0; i < ob_addr_q.size() && i < e_addr_q.size(); i++) begin
         n_checks++; if (ob_addr_q[i] !== e_addr_q[i]) begin n_fail++; $display("FAIL wrap_addr[%0d] got %h expected %h", i, ob_addr_q[i], e_addr_q[i]); end
      end
      n_checks++; if (ob_addr_q.size() > 0 && ob_addr_q[0] !== BASE + 32'(1021 * 32)) begin n_fail++; $display("FAIL wrap_first_addr got %h expected %h", ob_addr_q[0], BASE + 32'(1021 * 32)); end
      n_checks++; if (ob_pos_q.size() !== 4) begin n_fail++; $display("FAIL wrap_nrecs got %0d expected 4", ob_pos_q.size()); end
      for (int i = 0; i < ob_pos_q.size() && i < e_pos_q.size(); i++) begin
         n_checks++; if (ob_pos_q[i] !== e_pos_q[i]) begin n_fail++; $display("FAIL wrap_idx[%0d] got %0d expected %0d", i, ob_pos_q[i], e_pos_q[i]); end
         n_checks++; if (ob_data_q[i] !== mem[e_mem_q[i]]) begin n_fail++; $display("FAIL wrap_data[%0d] got %h expected %h", i, ob_data_q[i], mem[e_mem_q[i]]); end
      end
      n_checks++; if (done_cnt !== 1 || done_cyc !== e_cycles) begin n_fail++; $display("FAIL wrap_done got cnt %0d cyc %0d expected 1 / %0d", done_cnt, done_cyc, e_cycles); end
   endtask

   task automatic test_full();
      fill_mem();
      build_expect(32'd2, 32'd1024, 1'b0);
      do_dump(32'd2, 32'd1024, 1'b0, 100, 1'b0);
      n_checks++; if (ob_addr_q.size() !== 2048) begin n_fail++; $display("FAIL full_nreads got %0d expected 2048", ob_addr_q.size()); end
      for (int i = 0; i < ob_addr_q.size() && i < e_addr_q.size(); i++) begin
         n_checks++; if (ob_addr_q[i] !== e_addr_q[i]) begin n_fail++; $display("FAIL full_addr[%0d] got %h expected %h", i, ob_addr_q[i], e_addr_q[i]); end
      end
      n_checks++; if (ob_pos_q.size() !== 1024) begin n_fail++; $display("FAIL full_nrecs got %0d expected 1024", ob_pos_q.size()); end
      for (int i = 0; i < ob_pos_q.size() && i < 1024; i++) begin
         n_checks++; if (ob_pos_q[i] !== i) begin n_fail++; $display("FAIL full_idx[%0d] got %0d expected %0d", i, ob_pos_q[i], i); end
         n_checks++; if (ob_data_q[i] !== mem[(2 + i) % DEPTH]) begin n_fail++; $display("FAIL full_data[%0d] got %h expected %h", i, ob_data_q[i], mem[(2 + i) % DEPTH]); end
      end
      n_checks++; if (done_cnt !== 1 || done_cyc !== 4097) begin n_fail++; $display("FAIL full_done got cnt %0d cyc %0d expected 1 / 4097", done_cnt, done_cyc); end
   endtask

   task automatic test_empty();
      do_dump(32'd7, 32'd0, 1'b0, 100, 1'b0);
      n_checks++; if (ob_addr_q.size() !== 0) begin n_fail++; $display("FAIL empty_reads got %0d expected 0", ob_addr_q.size()); end
      n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL empty_busy got %0d expected 0", busy_seen); end
      n_checks++; if (done_cyc !== 1 || done_cnt !== 1) begin n_fail++; $display("FAIL empty_done got cyc %0d cnt %0d expected 1 / 1", done_cyc, done_cnt); end
   endtask

   task automatic test_stall_abort();
      int cyc;
      fill_mem();
      build_expect(32'd100, 32'd3, 1'b0);
      @(negedge clk_i);
      trace_ptr_i = 32'd100; trace_count_i = 32'd3; start_i = 1'b1; rec_ready_i = 1'b0;
      @(negedge clk_i);
      start_i = 1'b0;
      for (cyc = 1; cyc < 20 && !rec_valid_o; cyc++) @(negedge clk_i);
      n_checks++; if (rec_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid_timeout got %b expected 1", rec_valid_o); end
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (rec_valid_o !== 1'b1 || rec_idx_o !== 11'd0 || rec_data_o !== mem[e_mem_q[0]] || trace_mem_en_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold[%0d] got v%b idx %0d en %b data %h expected v1 idx 0 en 0 data %h", i, rec_valid_o, rec_idx_o, trace_mem_en_o, rec_data_o, mem[e_mem_q[0]]);
         end
         @(negedge clk_i);
      end
      abort_i = 1'b1;
      #1;
      n_checks++; if (rec_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_valid_drop got %b expected 0", rec_valid_o); end
      @(negedge clk_i);
      abort_i = 1'b0;
      n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b1) begin n_fail++; $display("FAIL abort_idle got busy %b done %b expected 0 / 1", busy_o, done_o); end
      @(negedge clk_i);
      n_checks++; if (done_o !== 1'b0 || rec_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_single_done got done %b valid %b expected 0 / 0", done_o, rec_valid_o); end
   endtask

   task automatic test_abort_start();
      @(negedge clk_i);
      trace_ptr_i = 32'd9; trace_count_i = 32'd5; start_i = 1'b1; abort_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; abort_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if ({busy_o, done_o, trace_mem_en_o} !== 3'b000) begin n_fail++; $display("FAIL abort_start[%0d] got %b expected 000", i, {busy_o, done_o, trace_mem_en_o}); end
         @(negedge clk_i);
      end
   endtask

   // Random pointers/counts with random back-pressure; back-to-back dumps,
   // and a start pulse mid-dump that must be ignored.
   task automatic test_random();
      logic [31:0] ptr, cnt;
      logic        filt;
      for (int it = 0; it < 8; it++) begin
         fill_mem();
         ptr  = $urandom();
         cnt  = 32'($urandom_range(0, 40));
         filt = 1'b0;
`ifdef BOOM_TRACE_READER_EXCFILTER_EN
         filt = 1'($urandom());
`endif
         build_expect(ptr, cnt, filt);
         do_dump(ptr, cnt, filt, 60, cnt >= 3);
         n_checks++; if (ob_addr_q.size() !== e_addr_q.size()) begin n_fail++; $display("FAIL rand%0d_nreads got %0d expected %0d", it, ob_addr_q.size(), e_addr_q.size()); end
         for (int i = 0; i < ob_addr_q.size() && i < e_addr_q.size(); i++) begin
            n_checks++; if (ob_addr_q[i] !== e_addr_q[i]) begin n_fail++; $display("FAIL rand%0d_addr[%0d] got %h expected %h", it, i, ob_addr_q[i], e_addr_q[i]); end
         end
         n_checks++; if (ob_pos_q.size() !== e_pos_q.size()) begin n_fail++; $display("FAIL rand%0d_nrecs got %0d expected %0d", it, ob_pos_q.size(), e_pos_q.size()); end
         for (int i = 0; i < ob_pos_q.size() && i < e_pos_q.size(); i++) begin
            n_checks++; if (ob_pos_q[i] !== e_pos_q[i]) begin n_fail++; $display("FAIL rand%0d_idx[%0d] got %0d expected %0d", it, i, ob_pos_q[i], e_pos_q[i]); end
            n_checks++; if (ob_data_q[i] !== mem[e_mem_q[i]]) begin n_fail++; $display("FAIL rand%0d_data[%0d] got %h expected %h", it, i, ob_data_q[i], mem[e_mem_q[i]]); end
         end
         n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_done_count got %0d expected 1", it, done_cnt); end
      end
   endtask

`ifdef BOOM_TRACE_READER_EXCFILTER_EN
   task automatic test_filter();
      fill_mem();
      for (int k = 0; k < 4; k++) begin
         mem[k][67] = k[0];
         mem[k][68] = 1'b0;
      end
      build_expect(32'd4, 32'd4, 1'b1);
      do_dump(32'd4, 32'd4, 1'b1, 100, 1'b0);
      n_checks++; if (ob_pos_q.size() !== 2) begin n_fail++; $display("FAIL filter_nrecs got %0d expected 2", ob_pos_q.size()); end
      for (int i = 0; i < ob_pos_q.size() && i < 2; i++) begin
         n_checks++; if (ob_pos_q[i] !== 2 * i + 1) begin n_fail++; $display("FAIL filter_idx[%0d] got %0d expected %0d", i, ob_pos_q[i], 2 * i + 1); end
         n_checks++; if (ob_data_q[i] !== mem[2 * i + 1]) begin n_fail++; $display("FAIL filter_data[%0d] got %h expected %h", i, ob_data_q[i], mem[2 * i + 1]); end
      end
      n_checks++; if (ob_addr_q.size() !== 8) begin n_fail++; $display("FAIL filter_nreads got %0d expected 8", ob_addr_q.size()); end
      n_checks++; if (done_cnt !== 1 || done_cyc !== 15) begin n_fail++; $display("FAIL filter_done got cnt %0d cyc %0d expected 1 / 15", done_cnt, done_cyc); end
   endtask
`endif

   initial begin
      repeat (3) @(negedge clk_i);
      test_reset();
      test_basic();
      test_wrap();
      test_empty();
      test_stall_abort();
      test_abort_start();
      test_full();
      test_random();
`ifdef BOOM_TRACE_READER_EXCFILTER_EN
      test_filter();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
